sync_pattern_det: RTL and testbench

SYNC_PATTERN_DET -- requirements
Module: sync_pattern_det

---
 rtl/sync_pkg.sv | 23 ++
 rtl/sat_counter.sv | 24 ++
 rtl/sync_pattern_det.sv | 126 ++++++++++++
 tb/tb_sync_pattern_det.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared types for the sync pattern detector: FSM state encoding and
// line-symbol classes derived from the {k, j} pair.
package sync_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXP_J     = 2'd1,
    EXP_K     = 2'd2,
    EXP_LASTK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SYM_SE0 = 2'b00,
    SYM_J   = 2'b01,
    SYM_K   = 2'b10,
    SYM_INV = 2'b11
  } sym_t;

  function automatic sym_t classify(input logic k, input logic j);
    return sym_t'({k, j});
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; rst and clr both win over inc.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/sync_pattern_det.sv
// Detects K, SYNC_PAIRS x (J,K), K on a qualified K/J line with a gap timeout.
// Define SYNC_ERR_CNT_EN to add the saturating abort counter on err_cnt.
module sync_pattern_det
  import sync_pkg::*;
#(
  parameter int SYNC_PAIRS  = 3,
  parameter int GAP_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             k,
  input  logic             j,
  input  logic             rx_en,
  input  logic             clr_cnt,
  output logic             synced,
  output logic             sync_err,
  output logic             locked,
  output state_t           dbg_state
`ifdef SYNC_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam logic [3:0] PAIRS    = 4'(SYNC_PAIRS);
  localparam logic [7:0] GAP_LAST = 8'(GAP_TIMEOUT - 1);

  state_t     r_state;
  logic [3:0] r_pair;
  logic [7:0] r_gap;
  logic       r_synced;
  logic       r_sync_err;
  logic       r_locked;

  sym_t       w_sym;
  logic       w_abort;
  logic       w_match;

  // A symbol is only meaningful while rx_en is high; rx_en low mid-pattern
  // is a gap that holds state until GAP_TIMEOUT consecutive low cycles.
  always_comb begin
    w_sym   = classify(k, j);
    w_abort = 1'b0;
    w_match = 1'b0;
    if (r_state != IDLE) begin
      if (!rx_en) begin
        w_abort = (r_gap == GAP_LAST);
      end else begin
        case (r_state)
          EXP_J:     w_abort = (w_sym != SYM_J);
          EXP_K:     w_abort = (w_sym != SYM_K);
          EXP_LASTK: begin
            w_abort = (w_sym != SYM_K);
            w_match = (w_sym == SYM_K);
          end
          default:   w_abort = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pair     <= '0;
      r_gap      <= '0;
      r_synced   <= 1'b0;
      r_sync_err <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_synced   <= w_match;
      r_sync_err <= w_abort;
      if (w_match) begin
        r_locked <= 1'b1;
      end else if (w_abort) begin
        r_locked <= 1'b0;
      end

      // The offending symbol of an abort is consumed, never a new start.
      if (w_abort) begin
        r_state <= IDLE;
        r_pair  <= '0;
        r_gap   <= '0;
      end else if (r_state == IDLE) begin
        r_gap <= '0;
        if (rx_en && (w_sym == SYM_K)) begin
          r_state <= EXP_J;
          r_pair  <= '0;
        end
      end else if (!rx_en) begin
        r_gap <= r_gap + 8'd1;
      end else begin
        r_gap <= '0;
        case (r_state)
          EXP_J: begin
            r_pair  <= r_pair + 4'd1;
            r_state <= EXP_K;
          end
          EXP_K:   r_state <= (r_pair == PAIRS) ? EXP_LASTK : EXP_J;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign synced    = r_synced;
  assign sync_err  = r_sync_err;
  assign locked    = r_locked;
  assign dbg_state = r_state;

`ifdef SYNC_ERR_CNT_EN
  sat_counter #(
    .WIDTH(CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_abort),
    .clr (clr_cnt),
    .cnt (err_cnt)
  );
`else
  wire [CNT_W-1:0] w_unused_cnt = {CNT_W{clr_cnt}};
`endif

endmodule

// File: tb/tb_sync_pattern_det.sv
// Directed bench for sync_pattern_det: SYNC_PAIRS=3 main instance (CNT_W=2)
// plus a SYNC_PAIRS=1 instance sharing the same line inputs.
module tb_sync_pattern_det;
  import sync_pkg::*;

  localparam int CNT_W = 2;

  logic   clk = 1'b0;
  logic   rst, k, j, rx_en, clr_cnt;
  logic   synced, sync_err, locked;
  state_t dbg_state;
  logic   synced1, sync_err1, locked1;
  state_t dbg_state1;
`ifdef SYNC_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt, err_cnt1;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  sync_pattern_det #(
    .SYNC_PAIRS(3), .GAP_TIMEOUT(16), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .k(k), .j(j), .rx_en(rx_en), .clr_cnt(clr_cnt),
    .synced(synced), .sync_err(sync_err), .locked(locked),
    .dbg_state(dbg_state)
`ifdef SYNC_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  sync_pattern_det #(
    .SYNC_PAIRS(1), .GAP_TIMEOUT(16), .CNT_W(CNT_W)
  ) dut1 (
    .clk(clk), .rst(rst), .k(k), .j(j), .rx_en(rx_en), .clr_cnt(clr_cnt),
    .synced(synced1), .sync_err(sync_err1), .locked(locked1),
    .dbg_state(dbg_state1)
`ifdef SYNC_ERR_CNT_EN
    , .err_cnt(err_cnt1)
`endif
  );

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one symbol at a negedge; outputs are checked at the next negedge.
  task automatic step(input logic kk, input logic jj, input logic en, input logic cc,
                      input logic s, input logic e, input logic l, input state_t st,
                      input string tag);
    logic [4:0] expv;
    k = kk; j = jj; rx_en = en; clr_cnt = cc;
    exp_q.push_back({s, e, l, st});
    @(negedge clk);
    expv = exp_q.pop_front();
    cmp(tag, {3'b000, synced, sync_err, locked, dbg_state}, {3'b000, expv});
  endtask

  task automatic sk(input logic s, input logic e, input logic l, input state_t st, input string tag);
    step(1'b1, 1'b0, 1'b1, 1'b0, s, e, l, st, tag);
  endtask

  task automatic sj(input logic s, input logic e, input logic l, input state_t st, input string tag);
    step(1'b0, 1'b1, 1'b1, 1'b0, s, e, l, st, tag);
  endtask

  task automatic gap(input logic e, input logic l, input state_t st, input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e, l, st, tag);
  endtask

  // K J K J K J K K from IDLE; l0 is the locked level going in.
  task automatic full_pattern(input logic l0, input string tag);
    sk(0, 0, l0, EXP_J, tag);
    sj(0, 0, l0, EXP_K, tag);
    sk(0, 0, l0, EXP_J, tag);
    sj(0, 0, l0, EXP_K, tag);
    sk(0, 0, l0, EXP_J, tag);
    sj(0, 0, l0, EXP_K, tag);
    sk(0, 0, l0, EXP_LASTK, tag);
    sk(1, 0, 1, IDLE, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; k = 1'b0; j = 1'b0; rx_en = 1'b0; clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    cmp("reset", {3'b000, synced, sync_err, locked, dbg_state}, 8'h00);
`ifdef SYNC_ERR_CNT_EN
    cmp("reset_cnt", 8'(err_cnt), 8'h00);
`endif
    rst = 1'b0;

    // Non-K symbols and idle line in IDLE: no start, no error.
    sj(0, 0, 0, IDLE, "idle_j");
    step(0, 0, 1, 0, 0, 0, 0, IDLE, "idle_se0");
    step(1, 1, 1, 0, 0, 0, 0, IDLE, "idle_inv");
    gap(0, 0, IDLE, "idle_gap");

    full_pattern(1'b0, "match_basic");
    gap(0, 1, IDLE, "locked_hold");

    // Gap of 5 cycles between symbols 3 and 4.
    sk(0, 0, 1, EXP_J, "gap5");
    sj(0, 0, 1, EXP_K, "gap5");
    sk(0, 0, 1, EXP_J, "gap5");
    for (int i = 0; i < 5; i++) gap(0, 1, EXP_J, "gap5_hold");
    sj(0, 0, 1, EXP_K, "gap5");
    sk(0, 0, 1, EXP_J, "gap5");
    sj(0, 0, 1, EXP_K, "gap5");
    sk(0, 0, 1, EXP_LASTK, "gap5");
    sk(1, 0, 1, IDLE, "gap5_match");

    // 15 low cycles hold, the 16th aborts.
    sk(0, 0, 1, EXP_J, "gap_to");
    sj(0, 0, 1, EXP_K, "gap_to");
    for (int i = 0; i < 15; i++) gap(0, 1, EXP_K, "gap_to_hold");
    gap(1, 0, IDLE, "gap_timeout");
`ifdef SYNC_ERR_CNT_EN
    cmp("cnt_after_gap", 8'(err_cnt), 8'd1);
`endif
    gap(0, 0, IDLE, "err_pulse_end");

    // Invalid symbol abort, then recovery.
    sk(0, 0, 0, EXP_J, "inv");
    sj(0, 0, 0, EXP_K, "inv");
    sk(0, 0, 0, EXP_J, "inv");
    step(1, 1, 1, 0, 0, 1, 0, IDLE, "inv_abort");
`ifdef SYNC_ERR_CNT_EN
    cmp("cnt_after_inv", 8'(err_cnt), 8'd2);
`endif
    full_pattern(1'b0, "match_after_inv");

    // K where J expected: abort, and that K is not a new start.
    sk(0, 0, 1, EXP_J, "kk");
    sk(0, 1, 0, IDLE, "kk_abort");
`ifdef SYNC_ERR_CNT_EN
    cmp("cnt_after_kk", 8'(err_cnt), 8'd3);
`endif
    gap(0, 0, IDLE, "kk_idle");

    sk(0, 0, 0, EXP_J, "se0");
    step(0, 0, 1, 0, 0, 1, 0, IDLE, "se0_abort");
    sk(0, 0, 0, EXP_J, "jj");
    sj(0, 0, 0, EXP_K, "jj");
    sj(0, 1, 0, IDLE, "jj_abort");
`ifdef SYNC_ERR_CNT_EN
    cmp("cnt_saturated", 8'(err_cnt), 8'd3);
`endif

    // clr_cnt together with an abort clears the counter.
    sk(0, 0, 0, EXP_J, "clr");
    step(0, 0, 1, 1, 0, 1, 0, IDLE, "clr_abort");
`ifdef SYNC_ERR_CNT_EN
    cmp("cnt_clr_wins", 8'(err_cnt), 8'd0);
`endif

    // Reset mid-pattern while locked.
    full_pattern(1'b0, "match_pre_rst");
    sk(0, 0, 1, EXP_J, "pre_rst");
    sj(0, 0, 1, EXP_K, "pre_rst");
    sk(0, 0, 1, EXP_J, "pre_rst");
    sj(0, 0, 1, EXP_K, "pre_rst");
    rst = 1'b1; k = 1'b1; j = 1'b0; rx_en = 1'b1; clr_cnt = 1'b0;
    @(negedge clk);
    cmp("mid_rst", {3'b000, synced, sync_err, locked, dbg_state}, 8'h00);
    cmp("mid_rst_p1", {3'b000, synced1, sync_err1, locked1, dbg_state1}, 8'h00);
    rst = 1'b0;
    gap(0, 0, IDLE, "post_rst");

    // SYNC_PAIRS=1: K J K K matches; the 3-pair instance aborts on the last K.
    sk(0, 0, 0, EXP_J, "p1");
    cmp("p1_k1", {3'b000, synced1, sync_err1, locked1, dbg_state1}, {6'b000000, EXP_J});
    sj(0, 0, 0, EXP_K, "p1");
    cmp("p1_j1", {3'b000, synced1, sync_err1, locked1, dbg_state1}, {6'b000000, EXP_K});
    sk(0, 0, 0, EXP_J, "p1");
    cmp("p1_k2", {3'b000, synced1, sync_err1, locked1, dbg_state1}, {6'b000000, EXP_LASTK});
    sk(0, 1, 0, IDLE, "p1_p3_abort");
    cmp("p1_match", {3'b000, synced1, sync_err1, locked1, dbg_state1}, {3'b000, 3'b101, IDLE});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
